// File: rtl/stopwatch_disp_pkg.sv
// Shared constants for the stopwatch display scanner: active-low segment codes
// and the digit-index type.
package stopwatch_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low a..g patterns for decimal digits; entry 9 is leftmost.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t IDX_LAST = 2'd3;
  localparam digit_idx_t IDX_SEP  = 2'd2;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder; non-BCD codes
// render as a dash and raise o_invalid.
module bcd_to_7seg
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg,
  output logic       o_invalid
);

  always_comb begin
    o_invalid = (i_bcd > 4'd9);
    o_seg     = SEG_DASH;
    for (int k = 0; k < 10; k++) begin
      if (i_bcd == 4'(k)) o_seg = SEG_TABLE[k];
    end
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 4-digit common-anode display driver with per-frame snapshot,
// leading-zero blanking, blink and sticky invalid-digit flag.
// Optional minutes/seconds separator on DP: define STOPWATCH_DP_SEPARATOR_EN.
module stopwatch_display_scan
  import stopwatch_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic [15:0] BCD_IN,
  input  logic        BLINK,
  input  logic        BLANK_LZ,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP,
  output logic        FRAME,
  output logic        ERR
);

  localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0] r_pre;
  digit_idx_t       r_idx;
  logic [15:0]      r_shadow;
  logic             r_load_pending;
  logic [BF_W-1:0]  r_bf_cnt;
  logic             r_phase;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_err;

  logic             w_tick;
  logic             w_frame_end;
  logic [3:0][6:0]  w_dig_seg;
  logic [3:0]       w_dig_inv;
  logic             w_blank_slot;
  logic             w_blink_off;
  logic             w_hide;

  assign w_tick      = (r_pre == PRE_LAST);
  assign w_frame_end = w_tick && (r_idx == IDX_LAST);

  // All four shadow digits are decoded so ERR covers the whole snapshot.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    bcd_to_7seg u_dec (
      .i_bcd     (r_shadow[4*gi +: 4]),
      .o_seg     (w_dig_seg[gi]),
      .o_invalid (w_dig_inv[gi])
    );
  end

  assign w_blank_slot = BLANK_LZ &&
                        (((r_idx == 2'd3) && (r_shadow[15:12] == 4'd0)) ||
                         ((r_idx == 2'd2) && (r_shadow[15:8]  == 8'd0)));
  assign w_blink_off  = BLINK && r_phase;
  assign w_hide       = r_load_pending || w_blank_slot || w_blink_off;

  // The prescaler idles during the load cycle so digit0 gets a full slot.
  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_pre          <= '0;
      r_idx          <= '0;
      r_shadow       <= '0;
      r_load_pending <= 1'b1;
    end else if (r_load_pending) begin
      r_shadow       <= BCD_IN;
      r_load_pending <= 1'b0;
    end else begin
      if (w_tick) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      if (w_frame_end) r_shadow <= BCD_IN;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RESET || !BLINK) begin
      r_bf_cnt <= '0;
      r_phase  <= 1'b0;
    end else if (w_frame_end) begin
      if (r_bf_cnt == BF_LAST) begin
        r_bf_cnt <= '0;
        r_phase  <= ~r_phase;
      end else begin
        r_bf_cnt <= r_bf_cnt + BF_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | (|w_dig_inv);
      if (w_hide) begin
        r_an  <= 4'hF;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_dig_seg[r_idx];
      end
    end
  end

`ifdef STOPWATCH_DP_SEPARATOR_EN
  logic r_dp;

  always_ff @(posedge clk_in) begin
    if (RESET) r_dp <= 1'b1;
    else       r_dp <= w_hide || (r_idx != IDX_SEP);
  end

  assign DP = r_dp;
`else
  assign DP = 1'b1;
`endif

  assign SEG   = r_seg;
  assign AN    = r_an;
  assign FRAME = w_frame_end;
  assign ERR   = r_err;

endmodule
